gigerx_fifo_sync: RTL and testbench

Parametrised single-clock FIFO, the next generation of the gigerx 256x64 receive buffer. It carries 64-bit GigE receive data between the LMAC receive datapath and the host-side consumer in the same clock domain. Unlike its predecessor, it reports an exact fill count including the full condition, and provides programmable almost-full and almost-empty thresholds. It also offers a selectable first-word-fall-through read mode, a synchronous flush, and sticky overflow and underflow error flags.

---
 rtl/gigerx_fifo_sync_if.sv | 31 +++
 rtl/gigerx_fifo_sync.sv | 122 ++++++++++++
 tb/tb_gigerx_fifo_sync.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/gigerx_fifo_sync_if.sv
// Bundle of control, data and status signals between the gigerx receive FIFO and its users.
// Purely structural: no latency, no state, no backpressure of its own.
// The writer sees full/almost_full; the reader sees empty/almost_empty/q.
interface gigerx_fifo_sync_if #(
    parameter int WIDTH = 64,
    parameter int PTR   = 8
);
    logic             flush;
    logic             clr_err;
    logic             wrreq;
    logic [WIDTH-1:0] data;
    logic             full;
    logic             almost_full;
    logic             rdreq;
    logic [WIDTH-1:0] q;
    logic             empty;
    logic             almost_empty;
    logic [PTR:0]     usedw;
    logic             overflow;
    logic             underflow;

    modport master (
        output flush, clr_err, wrreq, data, rdreq,
        input  full, almost_full, q, empty, almost_empty, usedw, overflow, underflow
    );

    modport slave (
        input  flush, clr_err, wrreq, data, rdreq,
        output full, almost_full, q, empty, almost_empty, usedw, overflow, underflow
    );
endinterface

// File: rtl/gigerx_fifo_sync.sv
// Single-clock receive FIFO with exact fill count, programmable thresholds and sticky errors.
// Latency: write visible after 1 edge; read data 1 edge after rdreq (standard) or 0 (FWFT).
// Backpressure: writes dropped while full, reads ignored while empty; both set sticky flags.
module gigerx_fifo_sync #(
    parameter int WIDTH     = 64,
    parameter int PTR       = 8,
    parameter int DEPTH     = 256,
    parameter int AFULL_TH  = 240,
    parameter int AEMPTY_TH = 16,
    parameter int FWFT      = 0
) (
    input  logic              clk,
    input  logic              srst_n,
    gigerx_fifo_sync_if.slave fifo
);
    localparam logic [PTR:0] AFULL_V  = (PTR+1)'(AFULL_TH);
    localparam logic [PTR:0] AEMPTY_V = (PTR+1)'(AEMPTY_TH);

    if (DEPTH != 2**PTR) begin : g_bad_depth
        $error("gigerx_fifo_sync: DEPTH must equal 2**PTR");
    end
    if (AFULL_TH < 1 || AFULL_TH > DEPTH) begin : g_bad_afull
        $error("gigerx_fifo_sync: AFULL_TH out of range 1..DEPTH");
    end
    if (AEMPTY_TH < 0 || AEMPTY_TH > DEPTH - 1) begin : g_bad_aempty
        $error("gigerx_fifo_sync: AEMPTY_TH out of range 0..DEPTH-1");
    end

    logic [WIDTH-1:0] mem [DEPTH];

    logic [PTR:0]   wr_ptr;
    logic [PTR:0]   rd_ptr;
    logic [PTR:0]   wr_nxt;
    logic [PTR:0]   rd_nxt;
    logic [PTR:0]   used_nxt;
    logic [PTR:0]   usedw_r;
    logic [PTR-1:0] rd_addr;
    logic           full_r;
    logic           empty_r;
    logic           afull_r;
    logic           aempty_r;
    logic           ovf_r;
    logic           unf_r;
    logic           wr_acc;
    logic           rd_acc;
    logic           ovf_set;
    logic           unf_set;

    assign rd_addr = rd_ptr[PTR-1:0];

    // Requests arriving alongside flush are ignored entirely, including error detection.
    always_comb begin
        wr_acc   = fifo.wrreq && !full_r  && !fifo.flush;
        rd_acc   = fifo.rdreq && !empty_r && !fifo.flush;
        ovf_set  = fifo.wrreq && full_r   && !fifo.flush;
        unf_set  = fifo.rdreq && empty_r  && !fifo.flush;
        wr_nxt   = fifo.flush ? '0 : wr_ptr + {{PTR{1'b0}}, wr_acc};
        rd_nxt   = fifo.flush ? '0 : rd_ptr + {{PTR{1'b0}}, rd_acc};
        used_nxt = wr_nxt - rd_nxt;
    end

    // Status is registered from next-state pointers so every flag is a clean flop output.
    always_ff @(posedge clk) begin
        if (!srst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            usedw_r  <= '0;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
            afull_r  <= 1'b0;
            aempty_r <= 1'b1;
            ovf_r    <= 1'b0;
            unf_r    <= 1'b0;
        end else begin
            wr_ptr   <= wr_nxt;
            rd_ptr   <= rd_nxt;
            usedw_r  <= used_nxt;
            full_r   <= (wr_nxt[PTR-1:0] == rd_nxt[PTR-1:0]) && (wr_nxt[PTR] != rd_nxt[PTR]);
            empty_r  <= (wr_nxt == rd_nxt);
            afull_r  <= (used_nxt >= AFULL_V);
            aempty_r <= (used_nxt <= AEMPTY_V);
            if (ovf_set) begin
                ovf_r <= 1'b1;
            end else if (fifo.clr_err) begin
                ovf_r <= 1'b0;
            end
            if (unf_set) begin
                unf_r <= 1'b1;
            end else if (fifo.clr_err) begin
                unf_r <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (srst_n && wr_acc) begin
            mem[wr_ptr[PTR-1:0]] <= fifo.data;
        end
    end

    if (FWFT != 0) begin : g_fwft
        assign fifo.q = empty_r ? '0 : mem[rd_addr];
    end else begin : g_std
        logic [WIDTH-1:0] q_r;
        always_ff @(posedge clk) begin
            if (!srst_n) begin
                q_r <= '0;
            end else if (rd_acc) begin
                q_r <= mem[rd_addr];
            end
        end
        assign fifo.q = q_r;
    end

    assign fifo.full         = full_r;
    assign fifo.empty        = empty_r;
    assign fifo.almost_full  = afull_r;
    assign fifo.almost_empty = aempty_r;
    assign fifo.usedw        = usedw_r;
    assign fifo.overflow     = ovf_r;
    assign fifo.underflow    = unf_r;
endmodule

// File: tb/tb_gigerx_fifo_sync.sv
// Bench for gigerx_fifo_sync: one standard-mode and one FWFT instance driven in lockstep
// against a queue-based reference model, with a negedge monitor comparing every cycle.
module tb_gigerx_fifo_sync;
    localparam int W  = 64;
    localparam int P  = 8;
    localparam int D  = 256;
    localparam int AF = 240;
    localparam int AE = 16;

    logic clk = 1'b0;
    logic srst_n = 1'b0;
    always #5 clk = ~clk;

    gigerx_fifo_sync_if #(.WIDTH(W), .PTR(P)) if0 ();
    gigerx_fifo_sync_if #(.WIDTH(W), .PTR(P)) if1 ();

    gigerx_fifo_sync #(.WIDTH(W), .PTR(P), .DEPTH(D), .AFULL_TH(AF), .AEMPTY_TH(AE), .FWFT(0))
        dut_std (.clk(clk), .srst_n(srst_n), .fifo(if0.slave));
    gigerx_fifo_sync #(.WIDTH(W), .PTR(P), .DEPTH(D), .AFULL_TH(AF), .AEMPTY_TH(AE), .FWFT(1))
        dut_fwft (.clk(clk), .srst_n(srst_n), .fifo(if1.slave));

    logic [W-1:0] mq[$];
    logic [W-1:0] exp_q[$];
    logic [W-1:0] m_qstd;
    bit           m_ovf;
    bit           m_unf;
    bit           armed = 1'b0;
    int           n_chk = 0;
    int           n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, exp);
        end
    endtask

    task automatic chk_st(input string t, input logic [P:0] u, input logic f, input logic e,
                          input logic af, input logic ae, input logic ov, input logic un);
        int sz;
        sz = mq.size();
        chk({t, ".usedw"}, 64'(u), 64'(sz));
        chk({t, ".full"}, 64'(f), 64'(sz == D));
        chk({t, ".empty"}, 64'(e), 64'(sz == 0));
        chk({t, ".almost_full"}, 64'(af), 64'(sz >= AF));
        chk({t, ".almost_empty"}, 64'(ae), 64'(sz <= AE));
        chk({t, ".overflow"}, 64'(ov), 64'(m_ovf));
        chk({t, ".underflow"}, 64'(un), 64'(m_unf));
    endtask

    // Monitor: scoreboard pops on every completed standard-mode read.
    always @(negedge clk) begin
        if (armed) begin
            chk_st("std", if0.usedw, if0.full, if0.empty, if0.almost_full, if0.almost_empty,
                   if0.overflow, if0.underflow);
            chk_st("fwft", if1.usedw, if1.full, if1.empty, if1.almost_full, if1.almost_empty,
                   if1.overflow, if1.underflow);
            chk("q_hold", if0.q, m_qstd);
            if (exp_q.size() > 0) chk("q_read", if0.q, exp_q.pop_front());
            if (mq.size() > 0) chk("q_fwft", if1.q, mq[0]);
        end
    end

    task automatic cycle(input bit w, input logic [W-1:0] d, input bit r,
                         input bit fl = 1'b0, input bit ce = 1'b0, input bit rst = 1'b0);
        bit full_m;
        bit emp_m;
        if0.wrreq = w;  if0.data = d;  if0.rdreq = r;  if0.flush = fl;  if0.clr_err = ce;
        if1.wrreq = w;  if1.data = d;  if1.rdreq = r;  if1.flush = fl;  if1.clr_err = ce;
        srst_n = !rst;
        full_m = (mq.size() == D);
        emp_m  = (mq.size() == 0);
        @(posedge clk);
        #1;
        if (rst) begin
            mq.delete();
            m_ovf  = 1'b0;
            m_unf  = 1'b0;
            m_qstd = '0;
        end else begin
            if (ce) begin
                m_ovf = 1'b0;
                m_unf = 1'b0;
            end
            if (fl) begin
                mq.delete();
            end else begin
                if (w && full_m) m_ovf = 1'b1;
                if (r && emp_m) m_unf = 1'b1;
                if (r && !emp_m) begin
                    m_qstd = mq.pop_front();
                    exp_q.push_back(m_qstd);
                end
                if (w && !full_m) mq.push_back(d);
            end
        end
    endtask

    initial begin
        int wp;
        int rp;
        bit fl;
        bit w;
        bit r;
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        armed = 1'b1;
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Fill to full, then one write too many.
        for (int i = 1; i <= 256; i++) cycle(1'b1, 64'(i), 1'b0);
        cycle(1'b1, 64'h999, 1'b0);

        // Drain, then one read too many; clear the errors.
        for (int i = 0; i < 257; i++) cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);

        // Sustained read+write at depth 5 across pointer wrap.
        for (int i = 0; i < 5; i++) cycle(1'b1, {$urandom, $urandom}, 1'b0);
        for (int i = 0; i < 1000; i++) cycle(1'b1, {$urandom, $urandom}, 1'b1);
        while (mq.size() > 0) cycle(1'b0, '0, 1'b1);

        // FWFT: data visible without rdreq.
        cycle(1'b1, 64'hAA, 1'b0);
        chk("fwft_aa_q", if1.q, 64'hAA);
        chk("fwft_aa_empty", 64'(if1.empty), 64'd0);
        cycle(1'b0, '0, 1'b1);

        // Flush together with a write at depth 10.
        for (int i = 0; i < 10; i++) cycle(1'b1, 64'(100 + i), 1'b0);
        cycle(1'b1, 64'h55, 1'b0, 1'b1);
        cycle(1'b0, '0, 1'b0);

        // Overflow then clear.
        for (int i = 0; i < 257; i++) cycle(1'b1, 64'(i * 3), 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, '0, 1'b0, 1'b1);

        // Mid-transfer reset at depth 100.
        for (int i = 0; i < 100; i++) cycle(1'b1, 64'(i + 7), 1'b0);
        cycle(1'b1, 64'h77, 1'b1, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 64'h1234, 1'b0);

        // Random traffic with shifting read/write bias.
        for (int ph = 0; ph < 4; ph++) begin
            wp = (ph == 0) ? 85 : (ph == 1) ? 15 : 50;
            rp = (ph == 0) ? 15 : (ph == 1) ? 85 : 50;
            for (int i = 0; i < 800; i++) begin
                fl = ($urandom_range(0, 99) == 0);
                w  = !fl && ($urandom_range(0, 99) < wp);
                r  = !fl && ($urandom_range(0, 99) < rp);
                cycle(w, {$urandom, $urandom}, r, fl, ($urandom_range(0, 49) == 0),
                      ($urandom_range(0, 499) == 0));
            end
        end
        cycle(1'b0, '0, 1'b0);
        @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
